// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register peripheral and its write sequencer:
// register map, frame format and sequencer FSM states.
package spi_reg_pkg;

  localparam logic [6:0] OUT_7_0    = 7'h00;
  localparam logic [6:0] OUT_15_8   = 7'h01;
  localparam logic [6:0] PWM_7_0    = 7'h02;
  localparam logic [6:0] PWM_15_8   = 7'h03;
  localparam logic [6:0] DUTY_CYCLE = 7'h04;

  localparam logic        SPI_WRITE  = 1'b1;
  localparam int unsigned FRAME_BITS = 16;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StHigh,
    StLow,
    StHold,
    StGap
  } seq_state_e;

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Loadable down-counter; tc flags the last cycle of a loaded duration (load value N-1 => N cycles).
module spi_halfperiod_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != '0) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q == '0);

endmodule

// File: rtl/spi_write_sequencer.sv
// Serialises one {write, addr, data} register write per handshake as a 16-bit SPI mode-0 frame.
// All outputs are flops loaded from the next-state decode.
module spi_write_sequencer
  import spi_reg_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [6:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic       sclk,
  output logic       cs_n,
  output logic       copi,
  output logic       busy,
  output logic       done
);

  localparam int unsigned MaxDur = (CLK_DIV > GAP) ? CLK_DIV : GAP;
  localparam int unsigned TimerW = $clog2(MaxDur + 1);

  seq_state_e            state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic [4:0]            bit_cnt_q, bit_cnt_d;

  logic              tmr_load;
  logic              tmr_tc;
  logic [TimerW-1:0] tmr_load_val;
  logic [TimerW-1:0] tmr_count;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d   = StSetup;
          shift_d   = {SPI_WRITE, cmd_addr, cmd_data};
          bit_cnt_d = '0;
        end
      end
      StSetup: if (tmr_tc) state_d = StHigh;
      StHigh: begin
        // Next bit is presented on the same edge that drops sclk.
        if (tmr_tc) begin
          state_d   = StLow;
          shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end
      StLow: begin
        if (tmr_tc) state_d = (bit_cnt_q == 5'(FRAME_BITS)) ? StHold : StHigh;
      end
      StHold: if (tmr_tc) state_d = StGap;
      StGap:  if (tmr_tc) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Every state change reloads the timer with the duration of the state being entered.
  assign tmr_load     = (state_d != state_q);
  assign tmr_load_val = (state_d == StGap) ? TimerW'(GAP - 1) : TimerW'(CLK_DIV - 1);

  spi_halfperiod_timer #(
    .WIDTH (TimerW)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .count    (tmr_count),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      cs_n      <= 1'b1;
      sclk      <= 1'b0;
      copi      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      cs_n      <= (state_d == StIdle) || (state_d == StGap);
      sclk      <= (state_d == StHigh);
      copi      <= (state_d inside {StSetup, StHigh, StLow, StHold}) ? shift_d[FRAME_BITS-1]
                                                                      : 1'b0;
      busy      <= (state_d != StIdle);
      cmd_ready <= (state_d == StIdle);
      // GAP >= 4 keeps count==1 inside the gap, so done lands on its final cycle.
      done      <= (state_q == StGap) && (tmr_count == TimerW'(1));
    end
  end

endmodule

// File: tb/tb_spi_write_sequencer.sv
// Directed bench: frame content, timing and reset behaviour for default and CLK_DIV=2/GAP=4 builds.
module tb_spi_write_sequencer;
  import spi_reg_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       sel = 1'b0;
  logic [6:0] cmd_addr = '0;
  logic [7:0] cmd_data = '0;

  always #5 clk = ~clk;

  logic v1, r1, s1, c1, p1, b1, d1;
  logic v2, r2, s2, c2, p2, b2, d2;
  logic cmd_ready, sclk, cs_n, copi, busy, done;

  assign v1 = cmd_valid & ~sel;
  assign v2 = cmd_valid & sel;

  assign cmd_ready = sel ? r2 : r1;
  assign sclk      = sel ? s2 : s1;
  assign cs_n      = sel ? c2 : c1;
  assign copi      = sel ? p2 : p1;
  assign busy      = sel ? b2 : b1;
  assign done      = sel ? d2 : d1;

  spi_write_sequencer u_dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (v1),
    .cmd_ready (r1),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .sclk      (s1),
    .cs_n      (c1),
    .copi      (p1),
    .busy      (b1),
    .done      (d1)
  );

  spi_write_sequencer #(
    .CLK_DIV (2),
    .GAP     (4)
  ) u_dut_fast (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (v2),
    .cmd_ready (r2),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .sclk      (s2),
    .cs_n      (c2),
    .copi      (p2),
    .busy      (b2),
    .done      (d2)
  );

  int n_checks = 0;
  int n_errors = 0;
  int last_tail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, ".cs_n"}, 32'(cs_n), 32'd1);
    check_eq({tag, ".sclk"}, 32'(sclk), 32'd0);
    check_eq({tag, ".copi"}, 32'(copi), 32'd0);
    check_eq({tag, ".busy"}, 32'(busy), 32'd0);
    check_eq({tag, ".done"}, 32'(done), 32'd0);
    check_eq({tag, ".ready"}, 32'(cmd_ready), 32'd1);
  endtask

  // Present a command and return just after its acceptance edge.
  task automatic send(input logic [6:0] a, input logic [7:0] d, input bit hold);
    int w = 0;
    @(negedge clk);
    cmd_addr  = a;
    cmd_data  = d;
    cmd_valid = 1'b1;
    while (!cmd_ready && w < 400) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) check_eq("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
  endtask

  // Observe one frame starting at the cycle after acceptance; ends at the first idle cycle.
  task automatic watch_frame(input string tag, input logic [15:0] exp, input int div,
                             input int gap);
    int k = 0, rises = 0, first_rise = 0, cs_low = 0, busy_n = 0;
    int dones = 0, done_at = 0, bad = 0, tail = 0;
    logic [15:0] word = '0;
    logic psclk = 1'b0, pcopi = 1'b0;
    bit ended = 1'b0;
    while (!ended && k < 400) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        check_eq({tag, ".cs_fall"}, 32'(cs_n), 32'd0);
        check_eq({tag, ".bit15"}, 32'(copi), 32'(exp[15]));
      end
      if (!busy) begin
        ended = 1'b1;
        check_eq({tag, ".ready_end"}, 32'(cmd_ready), 32'd1);
      end else begin
        busy_n++;
        if (!cs_n) begin
          cs_low++;
          tail = 0;
        end else begin
          tail++;
        end
        if (sclk && !psclk) begin
          rises++;
          if (rises == 1) first_rise = k;
          word = {word[14:0], copi};
        end
        if (sclk && psclk && (copi !== pcopi)) bad++;
        if (done) begin
          dones++;
          done_at = k;
        end
        psclk = sclk;
        pcopi = copi;
      end
    end
    if (!ended) check_eq({tag, ".timeout"}, 32'd0, 32'd1);
    check_eq({tag, ".first_rise"}, 32'(first_rise), 32'(1 + div));
    check_eq({tag, ".rises"}, 32'(rises), 32'd16);
    check_eq({tag, ".word"}, 32'(word), 32'(exp));
    check_eq({tag, ".cs_low"}, 32'(cs_low), 32'(34 * div));
    check_eq({tag, ".busy_len"}, 32'(busy_n), 32'(34 * div + gap));
    check_eq({tag, ".done_cnt"}, 32'(dones), 32'd1);
    check_eq({tag, ".done_at"}, 32'(done_at), 32'(34 * div + gap));
    check_eq({tag, ".copi_in_high"}, 32'(bad), 32'd0);
    last_tail = tail;
  endtask

  initial begin
    int rises;
    logic psclk;

    repeat (3) @(negedge clk);
    check_idle("reset_held");
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_rel");

    // Single write to DUTY_CYCLE.
    send(DUTY_CYCLE, 8'h80, 1'b0);
    watch_frame("single", 16'h8480, 4, 8);

    // Back-to-back with cmd_valid held; second command taken in the first idle cycle.
    send(OUT_7_0, 8'hA5, 1'b1);
    cmd_addr = PWM_15_8;
    cmd_data = 8'h3C;
    watch_frame("b2b0", 16'h80A5, 4, 8);
    check_eq("b2b.cs_high", 32'(last_tail + 1), 32'd9);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    watch_frame("b2b1", 16'h833C, 4, 8);

    // Reset after the 5th sclk rise; bit 11 of 0x8F00 is 1 so copi is high here.
    send(7'h0F, 8'h00, 1'b0);
    rises = 0;
    psclk = 1'b0;
    for (int i = 0; i < 200 && rises < 5; i++) begin
      @(negedge clk);
      if (sclk && !psclk) rises++;
      psclk = sclk;
    end
    check_eq("rst_mid.rises", 32'(rises), 32'd5);
    check_eq("rst_mid.sclk_pre", 32'(sclk), 32'd1);
    check_eq("rst_mid.copi_pre", 32'(copi), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_idle("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("rst_mid.no_done", 32'(done | busy), 32'd0);
    end
    send(OUT_15_8, 8'hFF, 1'b0);
    watch_frame("after_rst", 16'h81FF, 4, 8);

    // Out-of-range address goes out unchanged.
    send(7'h7F, 8'h55, 1'b0);
    watch_frame("oor", 16'hFF55, 4, 8);

    // Fast build.
    sel = 1'b1;
    @(negedge clk);
    check_idle("fast_idle");
    send(PWM_7_0, 8'h0F, 1'b0);
    watch_frame("fast", 16'h820F, 2, 4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/spi_write_sequencer.md
# spi_write_sequencer

On-chip SPI controller that programs the SPI register peripheral: accepts one register-write command (7-bit address, 8-bit data) per handshake and serialises it as a 16-bit mode-0 write frame on sclk/cs_n/copi. The frame timing leaves the peripheral's 2–3 flop input synchronisers enough margin. It sits between the system control logic and the peripheral's SPI pins. It is used on-chip and in benches to load the output-enable, PWM-enable and duty-cycle registers (addresses 0x00–0x04).

## Interface
Parameters:
- CLK_DIV, 4: clk cycles per sclk half-period. Legal values are ≥2.
- GAP, 8: clk cycles cs_n is held high after each frame. Legal values are ≥4.

Ports:
- clk  in  1  system clock (single clock domain)
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_addr  in  7  register address
- cmd_data  in  8  register data
- sclk  out  1  SPI clock, idles low (mode 0)
- cs_n  out  1  chip select, active low
- copi  out  1  serial data, MSB first
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at end of frame

## Operation
- Accept a command on a clk edge where cmd_valid && cmd_ready. Latch {1'b1, cmd_addr, cmd_data} into a 16-bit shift register; bit 15 is the write flag and is always 1.
- cmd_ready = (state == IDLE). A command presented while busy waits; it is neither dropped nor queued.
- FSM states:
  - IDLE: cs_n=1, sclk=0, copi=0. On accept, go to SETUP.
  - SETUP: cs_n=0, sclk=0, copi=frame[15]. Lasts CLK_DIV cycles, then go to HIGH.
  - HIGH: sclk=1 and copi is stable. Lasts CLK_DIV cycles, then go to LOW.
  - LOW: sclk=0. On entry, shift copi to the next bit. After bit 0's LOW phase, go to HOLD; otherwise go to HIGH. A 5-bit counter tracks 16 bits.
  - HOLD: cs_n=0, sclk=0. Lasts CLK_DIV cycles, then go to GAP.
  - GAP: cs_n=1. Lasts GAP cycles. done=1 in the last GAP cycle; then go to IDLE.
- Behaviour at the edges:
  - copi changes only while sclk is low.
  - Exactly 16 sclk rising edges per frame.
  - Addresses above 0x04 are sent unchanged; filtering is the peripheral's job.
- All outputs are registered. busy = (state != IDLE).
- Reset values: cs_n=1, sclk=0, copi=0, busy=0, done=0, cmd_ready=1. The shift register and counters are 0.
- Reset mid-frame: all outputs go to their idle values immediately (asynchronously). The partial frame has fewer than 16 edges, so the peripheral discards it. No done pulse is emitted.

## Timing
- Acceptance on edge T: cs_n falls and copi=bit 15 from T+1.
- The first sclk rise is CLK_DIV cycles after cs_n falls.
- Bit n is stable from the sclk fall before its rising edge until the sclk fall after it.
- Frame length in non-IDLE cycles is 34·CLK_DIV + GAP. With the defaults this is 144 cycles.
- done is high in cycle T+144 (defaults); cmd_ready is high again at T+145.
- Back-to-back commands:
  - A new command can be accepted in the first IDLE cycle.
  - The cs_n-high interval between frames is ≥ GAP+1 cycles.
  - This satisfies the peripheral's 3-cycle cs_n synchroniser plus one update cycle.
- Width rule: the timer counter is $clog2(max(CLK_DIV, GAP)+1) bits wide and reloads on every state entry.

## Structure
- Shared package spi_reg_pkg contains:
  - register address constants: OUT_7_0=0x00, OUT_15_8=0x01, PWM_7_0=0x02, PWM_15_8=0x03, DUTY_CYCLE=0x04
  - SPI_WRITE=1
  - FRAME_BITS=16
  - the FSM state enum
- The peripheral and benches import the same address constants.
- Sub-module spi_halfperiod_timer: a loadable down-counter with a terminal-count strobe, used for the SETUP/HIGH/LOW/HOLD/GAP durations. All other logic stays in the top module.

## Test plan
- Reset: assert rst mid-idle → cs_n=1, sclk=0, copi=0, busy=0, done=0, cmd_ready=1.
- Single write, addr 0x04 data 0x80, defaults:
  - copi samples 0x8480 MSB first on 16 sclk rises.
  - cs_n is low for 136 cycles.
  - done is pulsed once at T+144.
  - With the peripheral attached, pwm_duty_cycle=0x80.
- Back-to-back, addr 0x00/0xA5 then 0x03/0x3C with cmd_valid held:
  - The second command is accepted in the first IDLE cycle.
  - cs_n is high ≥9 cycles between frames.
  - The peripheral ends with en_reg_out_7_0=0xA5 and en_reg_pwm_15_8=0x3C.
- Reset pulse after the 5th sclk rise:
  - Outputs go idle in the same cycle.
  - Peripheral registers are unchanged.
  - A following write of 0x01/0xFF succeeds.
- Out-of-range address 0x7F, data 0x55 → the full 16-edge frame is sent and all peripheral registers are unchanged.
- CLK_DIV=2, GAP=4 build: write 0x02/0x0F → frame is 72 cycles and en_reg_pwm_7_0=0x0F.
